// File: rtl/ascon_pack.sv
`default_nettype none
// ============================================================================
//  Module   : ascon_pack
//  Purpose  : Shared types and constants for the ASCON-128 control sequencer:
//             FSM state encoding, last-round index, default pb start round.
//  Revision : 1.0  initial release
// ============================================================================
package ascon_pack;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_WAIT_AD = 3'd2,
        ST_AD      = 3'd3,
        ST_WAIT_PT = 3'd4,
        ST_PT      = 3'd5,
        ST_FINAL   = 3'd6,
        ST_DONE    = 3'd7
    } ctrl_state_t;

    localparam logic [3:0] ROUND_LAST    = 4'd11;
    localparam logic [3:0] ROUND_B_FIRST = 4'd6;

    // First round index of an n-round permutation so that it always ends on ROUND_LAST
    function automatic logic [3:0] first_round(input int rounds);
        return 4'(int'(ROUND_LAST) + 1 - rounds);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ascon_round_counter.sv
`default_nettype none
// ============================================================================
//  Module   : ascon_round_counter
//  Purpose  : Permutation round index. Loadable start value, increments while
//             enabled and saturates at the last round; flags the last round.
//  Revision : 1.0  initial release
// ============================================================================
module ascon_round_counter
    import ascon_pack::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_en,
    output logic [3:0] o_round,
    output logic       o_last
);

    logic [3:0] r_round;

    // Load has priority; counting stops at the last round so the index never exceeds it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_round <= 4'd0;
        end else if (i_load) begin
            r_round <= i_load_val;
        end else if (i_en && (r_round != ROUND_LAST)) begin
            r_round <= r_round + 4'd1;
        end
    end

    assign o_round = r_round;
    assign o_last  = (r_round == ROUND_LAST);

endmodule
`default_nettype wire

// File: rtl/ascon_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : ascon_ctrl_fsm
//  Purpose  : ASCON-128 AEAD sequencer. Walks init -> AD -> NB_BLOCKS plaintext
//             blocks -> finalisation one round per cycle and Moore-decodes the
//             datapath enables from state and round index.
//  Options  : ASCON_CTRL_PERF_EN adds a saturating 16-bit message cycle counter
//             on cycles_o.
//  Revision : 1.0  initial release
// ============================================================================
module ascon_ctrl_fsm
    import ascon_pack::*;
#(
    parameter int NB_BLOCKS = 4,
    parameter int ROUNDS_A  = 12,
    parameter int ROUNDS_B  = int'(ROUND_LAST) + 1 - int'(ROUND_B_FIRST)
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         start_i,
    input  logic                         data_valid_i,
    output logic [3:0]                   round_o,
    output logic [$clog2(NB_BLOCKS)-1:0] block_o,
    output logic                         init_state_o,
    output logic                         en_reg_state_o,
    output logic                         en_xor_begin_data_o,
    output logic                         en_xor_begin_key_o,
    output logic                         en_xor_end_key_o,
    output logic                         en_xor_lsb_o,
    output logic                         en_cipher_o,
    output logic                         en_tag_o,
    output logic                         data_ready_o,
    output logic                         cipher_valid_o,
    output logic                         end_o
`ifdef ASCON_CTRL_PERF_EN
    ,
    output logic [15:0]                  cycles_o
`endif
);

    localparam int BW = $clog2(NB_BLOCKS);

    localparam logic [3:0]    c_round_a_first = first_round(ROUNDS_A);
    localparam logic [3:0]    c_round_b_first = first_round(ROUNDS_B);
    localparam logic [BW-1:0] c_blk_last      = BW'(NB_BLOCKS - 1);

    ctrl_state_t   r_state;
    logic [BW-1:0] r_block;
    logic          r_cipher_valid;

    logic          w_load;
    logic [3:0]    w_load_val;
    logic          w_cnt_en;
    logic [3:0]    w_round;
    logic          w_last;
    logic          w_in_round;

    ascon_round_counter u_round_counter (
        .clk        (clock_i),
        .rst        (reset_i),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_en       (w_cnt_en),
        .o_round    (w_round),
        .o_last     (w_last)
    );

    // Round counter control: load on permutation entry, step through active rounds
    always_comb begin
        w_load     = 1'b0;
        w_load_val = 4'd0;
        w_cnt_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_load     = 1'b1;
                    w_load_val = c_round_a_first;
                end
            end
            ST_INIT, ST_AD, ST_PT, ST_FINAL: begin
                w_cnt_en = ~w_last;
            end
            ST_WAIT_AD: begin
                if (data_valid_i) begin
                    w_load     = 1'b1;
                    w_load_val = c_round_b_first;
                end
            end
            ST_WAIT_PT: begin
                if (data_valid_i) begin
                    w_load     = 1'b1;
                    w_load_val = (r_block < c_blk_last) ? c_round_b_first : c_round_a_first;
                end
            end
            ST_DONE: begin
                w_load     = 1'b1;
                w_load_val = 4'd0;
            end
            default: begin
            end
        endcase
    end

    // Sequencer state, block index and the delayed cipher-valid strobe
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state        <= ST_IDLE;
            r_block        <= '0;
            r_cipher_valid <= 1'b0;
        end else begin
            r_cipher_valid <= en_cipher_o;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) r_state <= ST_INIT;
                end
                ST_INIT: begin
                    if (w_last) r_state <= ST_WAIT_AD;
                end
                ST_WAIT_AD: begin
                    if (data_valid_i) r_state <= ST_AD;
                end
                ST_AD: begin
                    if (w_last) r_state <= ST_WAIT_PT;
                end
                ST_WAIT_PT: begin
                    if (data_valid_i) begin
                        r_state <= (r_block < c_blk_last) ? ST_PT : ST_FINAL;
                    end
                end
                ST_PT: begin
                    if (w_last) begin
                        r_block <= r_block + BW'(1);
                        r_state <= ST_WAIT_PT;
                    end
                end
                ST_FINAL: begin
                    if (w_last) r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_block <= '0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Moore decode of datapath enables from state and round index
    always_comb begin
        w_in_round = (r_state == ST_INIT) || (r_state == ST_AD) ||
                     (r_state == ST_PT)   || (r_state == ST_FINAL);

        init_state_o        = (r_state == ST_INIT) && (w_round == c_round_a_first);
        en_reg_state_o      = w_in_round;
        en_xor_begin_data_o = (((r_state == ST_AD) || (r_state == ST_PT)) && (w_round == c_round_b_first)) ||
                              ((r_state == ST_FINAL) && (w_round == c_round_a_first));
        en_xor_begin_key_o  = (r_state == ST_FINAL) && (w_round == c_round_a_first);
        en_xor_end_key_o    = ((r_state == ST_INIT) || (r_state == ST_FINAL)) && w_last;
        en_xor_lsb_o        = (r_state == ST_AD) && w_last;
        en_cipher_o         = ((r_state == ST_PT) && (w_round == c_round_b_first)) ||
                              ((r_state == ST_FINAL) && (w_round == c_round_a_first));
        en_tag_o            = (r_state == ST_FINAL) && w_last;
        data_ready_o        = (r_state == ST_WAIT_AD) || (r_state == ST_WAIT_PT);
        end_o               = (r_state == ST_DONE);
    end

    assign round_o        = w_round;
    assign block_o        = r_block;
    assign cipher_valid_o = r_cipher_valid;

`ifdef ASCON_CTRL_PERF_EN
    logic [15:0] r_cycles;

    // Message cycle counter; the launch cycle counts as the first message cycle so the
    // final value equals the inclusive start-to-end_o span
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_cycles <= 16'd0;
        end else if ((r_state == ST_IDLE) && start_i) begin
            r_cycles <= 16'd1;
        end else if ((r_state != ST_IDLE) && (r_cycles != 16'hFFFF)) begin
            r_cycles <= r_cycles + 16'd1;
        end
    end

    assign cycles_o = r_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ascon_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ascon_ctrl_fsm
//  Purpose  : Self-checking bench for ascon_ctrl_fsm. A message is modelled as
//             a queue of expected per-cycle records (phase, round, block,
//             enables); wait records repeat while data_valid_i is low.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ascon_ctrl_fsm;

    localparam int NB    = 4;
    localparam int C_LAT = 1 + 12 + 1 + 6 + (NB - 1) * 7 + 1 + 12 + 1;

    localparam logic [2:0] P_INIT  = 3'd0;
    localparam logic [2:0] P_WAIT  = 3'd1;
    localparam logic [2:0] P_AD    = 3'd2;
    localparam logic [2:0] P_PT    = 3'd3;
    localparam logic [2:0] P_FINAL = 3'd4;
    localparam logic [2:0] P_DONE  = 3'd5;

    localparam int F_INIT = 9;
    localparam int F_REG  = 8;
    localparam int F_XBD  = 7;
    localparam int F_XBK  = 6;
    localparam int F_XEK  = 5;
    localparam int F_LSB  = 4;
    localparam int F_CIP  = 3;
    localparam int F_TAG  = 2;
    localparam int F_RDY  = 1;
    localparam int F_END  = 0;

    typedef struct packed {
        logic [2:0] ph;
        logic       care;
        logic [3:0] round;
        logic [1:0] block;
        logic [9:0] flags;
    } rec_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       data_valid;
    logic [3:0] round_o;
    logic [1:0] block_o;
    logic       init_state_o, en_reg_state_o, en_xor_begin_data_o, en_xor_begin_key_o;
    logic       en_xor_end_key_o, en_xor_lsb_o, en_cipher_o, en_tag_o;
    logic       data_ready_o, cipher_valid_o, end_o;
`ifdef ASCON_CTRL_PERF_EN
    logic [15:0] cycles_o;
`endif

    int   checks;
    int   errors;
    rec_t exp_q[$];

    ascon_ctrl_fsm #(.NB_BLOCKS(NB)) dut (
        .clock_i             (clk),
        .reset_i             (rst),
        .start_i             (start),
        .data_valid_i        (data_valid),
        .round_o             (round_o),
        .block_o             (block_o),
        .init_state_o        (init_state_o),
        .en_reg_state_o      (en_reg_state_o),
        .en_xor_begin_data_o (en_xor_begin_data_o),
        .en_xor_begin_key_o  (en_xor_begin_key_o),
        .en_xor_end_key_o    (en_xor_end_key_o),
        .en_xor_lsb_o        (en_xor_lsb_o),
        .en_cipher_o         (en_cipher_o),
        .en_tag_o            (en_tag_o),
        .data_ready_o        (data_ready_o),
        .cipher_valid_o      (cipher_valid_o),
        .end_o               (end_o)
`ifdef ASCON_CTRL_PERF_EN
        ,
        .cycles_o            (cycles_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [9:0] obs_flags();
        return {init_state_o, en_reg_state_o, en_xor_begin_data_o, en_xor_begin_key_o,
                en_xor_end_key_o, en_xor_lsb_o, en_cipher_o, en_tag_o, data_ready_o, end_o};
    endfunction

    function automatic rec_t mk(input logic [2:0] ph, input logic care, input int rnd,
                                input int blk, input logic [9:0] fl);
        rec_t r;
        r.ph    = ph;
        r.care  = care;
        r.round = 4'(rnd);
        r.block = 2'(blk);
        r.flags = fl;
        return r;
    endfunction

    // Expected message: 12 init rounds, AD (6 rounds), NB-1 PT blocks, 12 final rounds
    task automatic build_expected();
        logic [9:0] fl;
        exp_q.delete();
        for (int r = 0; r < 12; r++) begin
            fl = '0; fl[F_REG] = 1'b1;
            if (r == 0)  fl[F_INIT] = 1'b1;
            if (r == 11) fl[F_XEK]  = 1'b1;
            exp_q.push_back(mk(P_INIT, 1'b1, r, 0, fl));
        end
        fl = '0; fl[F_RDY] = 1'b1;
        exp_q.push_back(mk(P_WAIT, 1'b1, 11, 0, fl));
        for (int r = 6; r < 12; r++) begin
            fl = '0; fl[F_REG] = 1'b1;
            if (r == 6)  fl[F_XBD] = 1'b1;
            if (r == 11) fl[F_LSB] = 1'b1;
            exp_q.push_back(mk(P_AD, 1'b1, r, 0, fl));
        end
        for (int b = 0; b < NB - 1; b++) begin
            fl = '0; fl[F_RDY] = 1'b1;
            exp_q.push_back(mk(P_WAIT, 1'b1, 11, b, fl));
            for (int r = 6; r < 12; r++) begin
                fl = '0; fl[F_REG] = 1'b1;
                if (r == 6) begin fl[F_XBD] = 1'b1; fl[F_CIP] = 1'b1; end
                exp_q.push_back(mk(P_PT, 1'b1, r, b, fl));
            end
        end
        fl = '0; fl[F_RDY] = 1'b1;
        exp_q.push_back(mk(P_WAIT, 1'b1, 11, NB - 1, fl));
        for (int r = 0; r < 12; r++) begin
            fl = '0; fl[F_REG] = 1'b1;
            if (r == 0)  begin fl[F_XBD] = 1'b1; fl[F_CIP] = 1'b1; fl[F_XBK] = 1'b1; end
            if (r == 11) begin fl[F_XEK] = 1'b1; fl[F_TAG] = 1'b1; end
            exp_q.push_back(mk(P_FINAL, 1'b1, r, NB - 1, fl));
        end
        fl = '0; fl[F_END] = 1'b1;
        exp_q.push_back(mk(P_DONE, 1'b0, 0, 0, fl));
    endtask

    // mode 0: valid tied 1; 1: random valid; 2: 10-cycle stall in WAIT_PT block 1;
    // 3: valid tied 1 with start pulses in AD and DONE. Entered/left at posedge+1.
    task automatic run_message(input int mode);
        rec_t h;
        int   cyc, end_cyc, n_end, n_cip, n_lsb, stall;
        logic prev_cip;
        build_expected();
        start      = 1'b1;
        data_valid = 1'($urandom_range(0, 1));
        #1;
        checks++;
        if (obs_flags() !== 10'd0) begin
            errors++;
            $display("FAIL launch_idle got=%b exp=%b", obs_flags(), 10'd0);
        end
        @(posedge clk); #1;
        start = 1'b0;
`ifdef ASCON_CTRL_PERF_EN
        checks++;
        if (cycles_o !== 16'd1) begin
            errors++;
            $display("FAIL perf_restart got=%0d exp=1", cycles_o);
        end
`endif
        cyc = 1; end_cyc = -1; n_end = 0; n_cip = 0; n_lsb = 0; stall = 0; prev_cip = 1'b0;
        while (exp_q.size() > 0) begin
            h = exp_q[0];
            case (mode)
                1: data_valid = 1'($urandom_range(0, 1));
                2: begin
                    if (h.ph == P_WAIT && h.block == 2'd1 && stall < 10) begin
                        data_valid = 1'b0;
                        stall++;
                    end else begin
                        data_valid = 1'b1;
                    end
                end
                default: data_valid = 1'b1;
            endcase
            start = (mode == 3) && (h.ph == P_AD || h.ph == P_DONE);
            #1;
            checks++;
            if (obs_flags() !== h.flags) begin
                errors++;
                $display("FAIL flags cyc=%0d ph=%0d got=%b exp=%b", cyc, h.ph, obs_flags(), h.flags);
            end
            checks++;
            if (cipher_valid_o !== prev_cip) begin
                errors++;
                $display("FAIL cipher_valid cyc=%0d got=%b exp=%b", cyc, cipher_valid_o, prev_cip);
            end
            if (h.care) begin
                checks++;
                if (round_o !== h.round || block_o !== h.block) begin
                    errors++;
                    $display("FAIL round_block cyc=%0d ph=%0d got=%0d/%0d exp=%0d/%0d",
                             cyc, h.ph, round_o, block_o, h.round, h.block);
                end
            end
            checks++;
            if (!(round_o <= 4'd11)) begin
                errors++;
                $display("FAIL round_range cyc=%0d got=%0d exp<=11", cyc, round_o);
            end
            if (end_o === 1'b1) begin
                n_end++;
                if (end_cyc < 0) end_cyc = cyc;
            end
            if (cipher_valid_o === 1'b1) n_cip++;
            if (en_xor_lsb_o === 1'b1)   n_lsb++;
            if (!(h.ph == P_WAIT && data_valid == 1'b0)) void'(exp_q.pop_front());
            prev_cip = h.flags[F_CIP];
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (obs_flags() !== 10'd0 || cipher_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL post_idle i=%0d got=%b/%b exp=0/0", i, obs_flags(), cipher_valid_o);
            end
            if (end_o === 1'b1) n_end++;
            @(posedge clk); #1;
        end
        checks++;
        if (n_end != 1) begin
            errors++;
            $display("FAIL end_count got=%0d exp=1", n_end);
        end
        checks++;
        if (n_cip != NB) begin
            errors++;
            $display("FAIL cipher_pulses got=%0d exp=%0d", n_cip, NB);
        end
        checks++;
        if (n_lsb != 1) begin
            errors++;
            $display("FAIL lsb_count got=%0d exp=1", n_lsb);
        end
        if (mode == 0 || mode == 3) begin
            checks++;
            if (end_cyc + 1 != C_LAT) begin
                errors++;
                $display("FAIL latency got=%0d exp=%0d", end_cyc + 1, C_LAT);
            end
`ifdef ASCON_CTRL_PERF_EN
            checks++;
            if (cycles_o !== 16'(C_LAT)) begin
                errors++;
                $display("FAIL perf_cycles got=%0d exp=%0d", cycles_o, C_LAT);
            end
`endif
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; data_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs_flags() !== 10'd0 || cipher_valid_o !== 1'b0 || round_o !== 4'd0 || block_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got=%b/%b/%0d/%0d exp=0/0/0/0",
                     obs_flags(), cipher_valid_o, round_o, block_o);
        end
`ifdef ASCON_CTRL_PERF_EN
        checks++;
        if (cycles_o !== 16'd0) begin
            errors++;
            $display("FAIL reset_perf got=%0d exp=0", cycles_o);
        end
`endif
        rst = 1'b0; start = 1'b0; data_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_full_message();
        run_message(0);
    endtask

    task automatic test_stall_wait_pt();
        run_message(2);
    endtask

    task automatic test_reset_mid_init();
        start = 1'b1; data_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (round_o !== 4'd5 || en_reg_state_o !== 1'b1) begin
            errors++;
            $display("FAIL init_round5 got=%0d/%b exp=5/1", round_o, en_reg_state_o);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (obs_flags() !== 10'd0 || cipher_valid_o !== 1'b0 || round_o !== 4'd0 || block_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid got=%b/%b/%0d/%0d exp=0/0/0/0",
                     obs_flags(), cipher_valid_o, round_o, block_o);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (obs_flags() !== 10'd0) begin
            errors++;
            $display("FAIL reset_mid_idle got=%b exp=%b", obs_flags(), 10'd0);
        end
        run_message(0);
    endtask

    task automatic test_start_ignored();
        run_message(3);
    endtask

    task automatic test_random_valid();
        for (int i = 0; i < 4; i++) run_message(1);
    endtask

    task automatic test_back_to_back();
        run_message(0);
        run_message(1);
        run_message(0);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; start = 1'b0; data_valid = 1'b0;
        test_reset();
        test_full_message();
        test_stall_wait_pt();
        test_reset_mid_init();
        test_start_ignored();
        test_random_valid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
